// File: rtl/dbg_cmd_frontend_if.sv
// Debug bus between the host-side command front end (master) and core_dbg_module (slave).
interface dbg_intf;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data_dbg_dut;
    logic [31:0] data_dut_dbg;
    logic        dut_done;

    modport master (output cmd, addr, data_dbg_dut, input data_dut_dbg, dut_done);
    modport slave  (input cmd, addr, data_dbg_dut, output data_dut_dbg, dut_done);
endinterface

// File: rtl/dbg_cmd_frontend.sv
// Byte-stream debug command front end: frames requests, drives dbg_intf, returns a response frame.
// Optional frame checksums are enabled by defining DBG_FRAME_CHK_EN.
module dbg_cmd_frontend #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rstn_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    dbg_intf.master    dbg_bus
);

`ifdef DBG_FRAME_CHK_EN
    localparam int unsigned REQ_LEN = 10;
    localparam int unsigned RSP_LEN = 6;
`else
    localparam int unsigned REQ_LEN = 9;
    localparam int unsigned RSP_LEN = 5;
`endif
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {S_RX, S_CHECK, S_WAIT, S_RELEASE, S_TX} state_t;

    state_t          state_q, state_d;
    logic [3:0]      rx_cnt_q;
    logic [2:0]      tx_cnt_q, tx_cnt_d;
    logic [7:0]      cmd_sh;
    logic [31:0]     addr_sh, data_sh;
    logic [7:0]      cmd_q;
    logic [31:0]     addr_q, data_q;
    logic [7:0]      status_q, status_d;
    logic [31:0]     resp_q, resp_d;
    logic [TO_W-1:0] to_cnt_q;
    logic            rx_fire, tx_fire, rx_last, tx_last;
    logic            cmd_legal, chk_ok, timeout_hit, load_cmd, drop_cmd;

`ifdef DBG_FRAME_CHK_EN
    // Running XOR over every request byte including the checksum; a good frame folds to zero.
    logic [7:0] rx_xor_q;
    assign chk_ok = (rx_xor_q == 8'h00);
`else
    assign chk_ok = 1'b1;
`endif

    assign rx_ready_o  = (state_q == S_RX);
    assign rx_fire     = rx_valid_i & rx_ready_o;
    assign tx_fire     = tx_valid_o & tx_ready_i;
    assign rx_last     = (rx_cnt_q == 4'(REQ_LEN - 1));
    assign tx_last     = (tx_cnt_q == 3'(RSP_LEN - 1));
    assign cmd_legal   = (cmd_sh >= 8'h01) && (cmd_sh <= 8'h06);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    assign dbg_bus.cmd          = cmd_q;
    assign dbg_bus.addr         = addr_q;
    assign dbg_bus.data_dbg_dut = data_q;

    function automatic logic [7:0] rsp_byte(input logic [2:0] idx, input logic [7:0] st,
                                            input logic [31:0] w);
        case (idx)
            3'd0:    return st;
            3'd1:    return w[7:0];
            3'd2:    return w[15:8];
            3'd3:    return w[23:16];
            3'd4:    return w[31:24];
`ifdef DBG_FRAME_CHK_EN
            default: return st ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
`else
            default: return 8'h00;
`endif
        endcase
    endfunction

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d  = state_q;
        tx_cnt_d = tx_cnt_q;
        status_d = status_q;
        resp_d   = resp_q;
        load_cmd = 1'b0;
        drop_cmd = 1'b0;
        case (state_q)
            S_RX: if (rx_fire && rx_last) state_d = S_CHECK;
            S_CHECK: begin
                if (!chk_ok) begin
                    status_d = 8'hEC;
                    resp_d   = '0;
                    state_d  = S_TX;
                end else if (cmd_legal) begin
                    load_cmd = 1'b1;
                    state_d  = S_WAIT;
                end else begin
                    status_d = 8'hE1;
                    resp_d   = '0;
                    state_d  = S_TX;
                end
            end
            S_WAIT: begin
                // A done arriving on the timeout cycle still returns real data.
                if (dbg_bus.dut_done) begin
                    status_d = 8'hA5;
                    resp_d   = dbg_bus.data_dut_dbg;
                    drop_cmd = 1'b1;
                    state_d  = S_RELEASE;
                end else if (timeout_hit) begin
                    status_d = 8'hEE;
                    resp_d   = '0;
                    drop_cmd = 1'b1;
                    state_d  = S_RELEASE;
                end
            end
            S_RELEASE: if (!dbg_bus.dut_done) state_d = S_TX;
            S_TX: begin
                if (tx_fire) begin
                    if (tx_last) begin
                        tx_cnt_d = '0;
                        state_d  = S_RX;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_RX;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_RX;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            cmd_sh     <= '0;
            addr_sh    <= '0;
            data_sh    <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            status_q   <= '0;
            resp_q     <= '0;
            to_cnt_q   <= '0;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
`ifdef DBG_FRAME_CHK_EN
            rx_xor_q   <= '0;
`endif
        end else begin
            // Address and data bytes arrive LSB first, so shift each new byte in at the top.
            if (rx_fire) begin
                rx_cnt_q <= rx_last ? 4'd0 : rx_cnt_q + 4'd1;
                if (rx_cnt_q == 4'd0)      cmd_sh  <= rx_data_i;
                else if (rx_cnt_q <= 4'd4) addr_sh <= {rx_data_i, addr_sh[31:8]};
                else if (rx_cnt_q <= 4'd8) data_sh <= {rx_data_i, data_sh[31:8]};
`ifdef DBG_FRAME_CHK_EN
                rx_xor_q <= (rx_cnt_q == 4'd0) ? rx_data_i : (rx_xor_q ^ rx_data_i);
`endif
            end

            if (load_cmd) begin
                cmd_q    <= cmd_sh;
                addr_q   <= addr_sh;
                data_q   <= data_sh;
                to_cnt_q <= '0;
            end else begin
                if (drop_cmd) cmd_q <= '0;
                if (state_q == S_WAIT) to_cnt_q <= to_cnt_q + TO_W'(1);
            end

            status_q   <= status_d;
            resp_q     <= resp_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_valid_o <= (state_d == S_TX);
            if (state_d == S_TX) tx_data_o <= rsp_byte(tx_cnt_d, status_d, resp_d);
        end
    end

endmodule

// File: tb/tb_dbg_cmd_frontend.sv
// Scoreboard bench for dbg_cmd_frontend: directed frames, a small core model and a tx monitor.
module tb_dbg_cmd_frontend;

    logic       clk = 1'b0;
    logic       rstn_i = 1'b0;
    logic [7:0] rx_data_i = '0;
    logic       rx_valid_i = 1'b0;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i = 1'b1;

    dbg_intf bus ();

    dbg_cmd_frontend #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rstn_i    (rstn_i),
        .rx_data_i (rx_data_i),
        .rx_valid_i(rx_valid_i),
        .rx_ready_o(rx_ready_o),
        .tx_data_o (tx_data_o),
        .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i),
        .dbg_bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    int rsp_cnt = 0;
    int cmd_hi = 0;

    bit          core_en = 1'b0;
    int          core_delay = 2;
    logic [31:0] core_data = '0;
    logic [7:0]  seen_cmd;
    logic [31:0] seen_addr, seen_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Core model: raises a registered done core_delay cycles after cmd goes non-zero.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn_i) begin
                bus.dut_done = 1'b0;
                bus.data_dut_dbg = '0;
                cnt = 0;
            end else if (bus.cmd != 8'h00) begin
                if (core_en && !bus.dut_done) begin
                    cnt++;
                    if (cnt >= core_delay) begin
                        bus.dut_done = 1'b1;
                        bus.data_dut_dbg = core_data;
                        seen_cmd = bus.cmd;
                        seen_addr = bus.addr;
                        seen_data = bus.data_dbg_dut;
                    end
                end
            end else begin
                bus.dut_done = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every tx handshake and counts cycles with a live command.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus.cmd != 8'h00) cmd_hi++;
            if (rstn_i && tx_valid_o && tx_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got %h want none", tx_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("tx_byte%0d", rsp_cnt), {24'h0, tx_data_o}, {24'h0, e});
                end
                rsp_cnt++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data_i = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rx_accept", {31'h0, rx_ready_o}, 32'h1);
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                              input bit corrupt = 1'b0);
        logic [7:0] b[9];
        logic [7:0] x;
        b[0] = c;
        for (int i = 0; i < 4; i++) begin
            b[1+i] = a[8*i +: 8];
            b[5+i] = d[8*i +: 8];
        end
        x = 8'h00;
        for (int i = 0; i < 9; i++) begin
            send_byte(b[i]);
            x = x ^ b[i];
        end
`ifdef DBG_FRAME_CHK_EN
        send_byte(corrupt ? ~x : x);
`else
        if (corrupt) x = 8'h00;
`endif
    endtask

    task automatic push_rsp(input logic [7:0] st, input logic [31:0] w);
        exp_q.push_back(st);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
`ifdef DBG_FRAME_CHK_EN
        exp_q.push_back(st ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
`endif
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_rsp_left"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        bit stable;
        logic [7:0] held;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", {31'h0, rx_ready_o}, 32'h1);
        check("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
        check("rst_cmd", {24'h0, bus.cmd}, 32'h0);
        check("rst_addr", bus.addr, 32'h0);
        check("rst_data", bus.data_dbg_dut, 32'h0);
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
        @(posedge clk);
        #1;

        // Halt: core done after 2 cycles.
        core_en = 1'b1; core_delay = 2; core_data = 32'h1234_5674;
        base = cmd_hi;
        push_rsp(8'hA5, 32'h1234_5674);
        send_frame(8'h01, 32'h0, 32'h0);
        wait_rsp("halt");
        check("halt_cmd", {24'h0, seen_cmd}, 32'h01);
        check("halt_cmd_cycles", cmd_hi - base, 2);
        check("halt_cmd_idle", {24'h0, bus.cmd}, 32'h0);

        // Read register x5.
        core_data = 32'hDEAD_BEEF;
        push_rsp(8'hA5, 32'hDEAD_BEEF);
        send_frame(8'h03, 32'd5, 32'h0);
        wait_rsp("read");
        check("read_cmd", {24'h0, seen_cmd}, 32'h03);
        check("read_addr", seen_addr, 32'd5);
        check("read_cmd_idle", {24'h0, bus.cmd}, 32'h0);

        // Write: data lane driven, addr/data kept after the command ends.
        core_delay = 1; core_data = 32'h5555_AAAA;
        push_rsp(8'hA5, 32'h5555_AAAA);
        send_frame(8'h04, 32'h0000_0010, 32'hCAFE_F00D);
        wait_rsp("write");
        check("write_data", seen_data, 32'hCAFE_F00D);
        check("write_addr", seen_addr, 32'h0000_0010);
        check("write_addr_kept", bus.addr, 32'h0000_0010);
        check("write_data_kept", bus.data_dbg_dut, 32'hCAFE_F00D);

        // Illegal commands never reach the bus.
        base = cmd_hi;
        push_rsp(8'hE1, 32'h0);
        send_frame(8'h09, 32'h1, 32'h2);
        wait_rsp("ill09");
        push_rsp(8'hE1, 32'h0);
        send_frame(8'h00, 32'h1, 32'h2);
        wait_rsp("ill00");
        check("illegal_cmd_cycles", cmd_hi - base, 0);

        // Timeout with a dead core.
        core_en = 1'b0;
        base = cmd_hi;
        push_rsp(8'hEE, 32'h0);
        send_frame(8'h02, 32'h0, 32'h0);
        wait_rsp("timeout");
        check("timeout_cmd_cycles", cmd_hi - base, 16);
        check("timeout_cmd_idle", {24'h0, bus.cmd}, 32'h0);

        // Backpressure: stall the PHY for 20 cycles after two response bytes.
        core_en = 1'b1; core_delay = 3; core_data = 32'h0BAD_F00D;
        push_rsp(8'hA5, 32'h0BAD_F00D);
        base = rsp_cnt;
        send_frame(8'h05, 32'h0, 32'h0);
        for (int n = 0; n < 500 && rsp_cnt < base + 2; n++) begin
            @(posedge clk);
            #1;
        end
        check("bp_reach", rsp_cnt - base, 2);
        tx_ready_i = 1'b0;
        held = tx_data_o;
        check("bp_hold_byte", {24'h0, held}, {24'h0, exp_q[0]});
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (tx_data_o !== held || tx_valid_o !== 1'b1 || rx_ready_o !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", {31'h0, stable}, 32'h1);
        tx_ready_i = 1'b1;
        wait_rsp("bp");
        check("bp_total_bytes", rsp_cnt - base, 5 + ((exp_q.size() == 0) ? 0 : 1) +
`ifdef DBG_FRAME_CHK_EN
              1
`else
              0
`endif
              );

        // Reset after four request bytes.
        send_byte(8'h03);
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h00);
        rstn_i = 1'b0;
        #1;
        check("rst_mid_rx_ready", {31'h0, rx_ready_o}, 32'h1);
        check("rst_mid_cmd", {24'h0, bus.cmd}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rstn_i = 1'b1;
        @(posedge clk);
        #1;
        core_delay = 2; core_data = 32'h0102_0304;
        push_rsp(8'hA5, 32'h0102_0304);
        send_frame(8'h03, 32'd9, 32'h0);
        wait_rsp("after_rst_rx");
        check("after_rst_rx_addr", seen_addr, 32'd9);

        // Reset while waiting on the core.
        core_en = 1'b0;
        send_frame(8'h06, 32'h40, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("wait_cmd_live", {24'h0, bus.cmd}, 32'h06);
        rstn_i = 1'b0;
        #1;
        check("rst_wait_cmd", {24'h0, bus.cmd}, 32'h0);
        check("rst_wait_tx_valid", {31'h0, tx_valid_o}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rstn_i = 1'b1;
        @(posedge clk);
        #1;
        core_en = 1'b1; core_data = 32'h7654_3210;
        push_rsp(8'hA5, 32'h7654_3210);
        send_frame(8'h03, 32'd7, 32'h0);
        wait_rsp("after_rst_wait");
        check("after_rst_wait_addr", seen_addr, 32'd7);

`ifdef DBG_FRAME_CHK_EN
        // Bad checksum beats both legal and illegal commands.
        base = cmd_hi;
        push_rsp(8'hEC, 32'h0);
        send_frame(8'h03, 32'd5, 32'h0, 1'b1);
        wait_rsp("chk_bad_legal");
        push_rsp(8'hEC, 32'h0);
        send_frame(8'h09, 32'd5, 32'h0, 1'b1);
        wait_rsp("chk_bad_illegal");
        check("chk_bad_cmd_cycles", cmd_hi - base, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
